conv33_mac_pe: RTL

Pipelined 3x3 multiply-accumulate processing element for the conv33 datapath. Latches the nine parallel weights when the weight buffer pulses `done`, then accepts one 3x3 pixel window per valid/ready beat. Each window produces a signed accumulator (dot product + bias) and a rounded, saturated requantized result. It sits directly downstream of the conv33 weight buffer and upstream of the output feature-map writer.

---
 rtl/conv33_mac_pe.sv | 113 +++++++++++
 1 files changed

// File: rtl/conv33_mac_pe.sv
// conv33_mac_pe: 4-stage pipelined 3x3 signed MAC with bias, round-half-up requantization,
// saturation and optional ReLU; all stages stall together on downstream backpressure.
module conv33_mac_pe #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 20,
   parameter int OUT_WIDTH  = 8,
   parameter int SHIFT      = 7,
   parameter int RELU       = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         weight_load,
   input  logic signed [DATA_WIDTH-1:0] weight_0,
   input  logic signed [DATA_WIDTH-1:0] weight_1,
   input  logic signed [DATA_WIDTH-1:0] weight_2,
   input  logic signed [DATA_WIDTH-1:0] weight_3,
   input  logic signed [DATA_WIDTH-1:0] weight_4,
   input  logic signed [DATA_WIDTH-1:0] weight_5,
   input  logic signed [DATA_WIDTH-1:0] weight_6,
   input  logic signed [DATA_WIDTH-1:0] weight_7,
   input  logic signed [DATA_WIDTH-1:0] weight_8,
   input  logic signed [ACC_WIDTH-1:0]  bias,
   input  logic signed [DATA_WIDTH-1:0] pix_0,
   input  logic signed [DATA_WIDTH-1:0] pix_1,
   input  logic signed [DATA_WIDTH-1:0] pix_2,
   input  logic signed [DATA_WIDTH-1:0] pix_3,
   input  logic signed [DATA_WIDTH-1:0] pix_4,
   input  logic signed [DATA_WIDTH-1:0] pix_5,
   input  logic signed [DATA_WIDTH-1:0] pix_6,
   input  logic signed [DATA_WIDTH-1:0] pix_7,
   input  logic signed [DATA_WIDTH-1:0] pix_8,
   input  logic                         valid_in,
   output logic                         ready_out,
   output logic signed [ACC_WIDTH-1:0]  acc_out,
   output logic signed [OUT_WIDTH-1:0]  data_out,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic                         weights_ok
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int RW = PW + 2;
   localparam int SW = ACC_WIDTH + 1;
   localparam logic signed [SW-1:0] L_HALF = SW'(1) << (SHIFT - 1);
   localparam logic signed [SW-1:0] L_MAX  = SW'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0] L_MIN  = ~L_MAX;

   logic signed [DATA_WIDTH-1:0] w_wt [9];
   logic signed [DATA_WIDTH-1:0] w_pix [9];
   logic signed [DATA_WIDTH-1:0] r_w [9];
   logic signed [PW-1:0]         r_p [9];
   logic signed [RW-1:0]         r_row [3];
   logic signed [ACC_WIDTH-1:0]  r_acc3, r_acc4;
   logic signed [OUT_WIDTH-1:0]  r_dout;
   logic                         r_v1, r_v2, r_v3, r_v4, r_wok;
   logic                         w_adv, w_take;
   logic signed [SW-1:0]         w_rnd, w_shr;
   logic signed [OUT_WIDTH-1:0]  w_sat, w_q;

   assign w_wt  = '{weight_0, weight_1, weight_2, weight_3, weight_4, weight_5, weight_6, weight_7, weight_8};
   assign w_pix = '{pix_0, pix_1, pix_2, pix_3, pix_4, pix_5, pix_6, pix_7, pix_8};

   // One extra bit of headroom so adding the rounding constant cannot wrap near +max.
   always_comb begin
      w_adv  = !r_v4 | ready_in;
      w_take = valid_in & r_wok & w_adv;
      w_rnd  = {r_acc3[ACC_WIDTH-1], r_acc3} + L_HALF;
      w_shr  = w_rnd >>> SHIFT;
      w_sat  = (w_shr > L_MAX) ? L_MAX[OUT_WIDTH-1:0] :
               (w_shr < L_MIN) ? L_MIN[OUT_WIDTH-1:0] : w_shr[OUT_WIDTH-1:0];
      w_q    = (RELU != 0 && w_sat[OUT_WIDTH-1]) ? '0 : w_sat;
   end

   assign ready_out  = r_wok & w_adv;
   assign valid_out  = r_v4;
   assign acc_out    = r_acc4;
   assign data_out   = r_dout;
   assign weights_ok = r_wok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w   <= '{default: '0};
         r_wok <= 1'b0;
      end else if (weight_load) begin
         r_w   <= w_wt;
         r_wok <= 1'b1;
      end
   end

   // Stage 1 reads r_w before a same-edge reload lands, so that beat keeps the old weights.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_v4   <= 1'b0;
         r_p    <= '{default: '0};
         r_row  <= '{default: '0};
         r_acc3 <= '0;
         r_acc4 <= '0;
         r_dout <= '0;
      end else if (w_adv) begin
         r_v1 <= w_take;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         r_v4 <= r_v3;
         for (int k = 0; k < 9; k++) r_p[k] <= PW'(w_pix[k]) * PW'(r_w[k]);
         for (int i = 0; i < 3; i++) r_row[i] <= RW'(r_p[3*i]) + RW'(r_p[3*i+1]) + RW'(r_p[3*i+2]);
         r_acc3 <= ACC_WIDTH'(r_row[0]) + ACC_WIDTH'(r_row[1]) + ACC_WIDTH'(r_row[2]) + bias;
         r_acc4 <= r_acc3;
         r_dout <= w_q;
      end
   end
endmodule
